// File: rtl/alu_pkg.sv
// Shared opcode encodings and widths for the alu_core datapath ALU.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOT   = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_SRL   = 4'b0111,
        OP_SRA   = 4'b1000,
        OP_SLT   = 4'b1001,
        OP_SLTU  = 4'b1010,
        OP_MUL   = 4'b1011,
        OP_PASSB = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder with subtract control; exports sum, carry-out and signed overflow.
module alu_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    logic [N-1:0] b_eff;
    logic [N:0]   full;

    // Subtract is A + ~B + 1, so carry=1 means "no borrow".
    always_comb begin
        b_eff    = sub ? ~b : b;
        full     = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
        sum      = full[N-1:0];
        carry    = full[N];
        overflow = (a[N-1] == b_eff[N-1]) && (full[N-1] != a[N-1]);
    end

endmodule

// File: rtl/alu_core.sv
// Parameterised N-bit ALU with registered result and NZCV flags (one-cycle latency).
// Optional multiply on opcode 1011 enabled by defining ALU_MUL_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] opcode,
    input  logic [N-1:0]        operandA,
    input  logic [N-1:0]        operandB,
    output logic [N-1:0]        result,
    output logic                C_Flag,
    output logic                O_Flag,
    output logic                N_Flag,
    output logic                Z_Flag
);

    localparam int SHW = $clog2(N);

    logic           addsub_sub;
    logic [N-1:0]   addsub_sum;
    logic           addsub_c;
    logic           addsub_v;
    logic [SHW-1:0] shamt;

    logic [N-1:0]   result_d, result_q;
    logic           c_d, c_q;
    logic           o_d, o_q;
    logic           n_d, n_q;
    logic           z_d, z_q;

    assign shamt      = operandB[SHW-1:0];
    assign addsub_sub = (opcode == OP_SUB) || (opcode == OP_SLT) || (opcode == OP_SLTU);

    alu_addsub #(.N(N)) u_addsub (
        .a        (operandA),
        .b        (operandB),
        .sub      (addsub_sub),
        .sum      (addsub_sum),
        .carry    (addsub_c),
        .overflow (addsub_v)
    );

    // Result mux and flag derivation; compares reuse the subtractor's sum/carry/overflow.
    always_comb begin
        result_d = {N{1'b0}};
        c_d      = 1'b0;
        o_d      = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                result_d = addsub_sum;
                c_d      = addsub_c;
                o_d      = addsub_v;
            end
            OP_AND:   result_d = operandA & operandB;
            OP_OR:    result_d = operandA | operandB;
            OP_XOR:   result_d = operandA ^ operandB;
            OP_NOT:   result_d = ~operandA;
            OP_SLL:   result_d = operandA << shamt;
            OP_SRL:   result_d = operandA >> shamt;
            OP_SRA:   result_d = $signed(operandA) >>> shamt;
            OP_SLT:   result_d = {{(N-1){1'b0}}, addsub_sum[N-1] ^ addsub_v};
            OP_SLTU:  result_d = {{(N-1){1'b0}}, ~addsub_c};
`ifdef ALU_MUL_EN
            OP_MUL:   result_d = operandA * operandB;
`endif
            OP_PASSB: result_d = operandB;
            default:  result_d = {N{1'b0}};
        endcase
        n_d = result_d[N-1];
        z_d = (result_d == {N{1'b0}});
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= {N{1'b0}};
            c_q      <= 1'b0;
            o_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            result_q <= result_d;
            c_q      <= c_d;
            o_q      <= o_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    assign result = result_q;
    assign C_Flag = c_q;
    assign O_Flag = o_q;
    assign N_Flag = n_q;
    assign Z_Flag = z_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (N=32): directed vectors plus random stimulus vs a reference model.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic [31:0] result;
    logic        C_Flag, O_Flag, N_Flag, Z_Flag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_core #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .operandA (operandA),
        .operandB (operandB),
        .result   (result),
        .C_Flag   (C_Flag),
        .O_Flag   (O_Flag),
        .N_Flag   (N_Flag),
        .Z_Flag   (Z_Flag)
    );

    // Reference: {result, C, O, N, Z} computed with plain wide arithmetic.
    function automatic logic [35:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c, o;
        logic [32:0] wide;
        longint      sa, sb, sr;
        int          amt;
        r    = 32'd0;
        c    = 1'b0;
        o    = 1'b0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        amt  = int'(b % 32'd32);
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0];
                c = wide[32];
                sr = sa + sb;
                o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                sr = sa - sb;
                o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  r = a << amt;
            4'd7:  r = a >> amt;
            4'd8:  r = $signed(a) >>> amt;
            4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'd11: r = a * b;
`endif
            4'd12: r = b;
            default: r = 32'd0;
        endcase
        return {r, c, o, r[31], (r == 32'd0)};
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        opcode   = op;
        operandA = a;
        operandB = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(4'd0, 32'd5, 32'd3);
        checks++;
        if ({result, C_Flag, O_Flag, N_Flag, Z_Flag} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state: got result=%h CONZ=%b%b%b%b, want all zero",
                     result, C_Flag, O_Flag, N_Flag, Z_Flag);
        end
        rst = 1'b0;
        step(4'd0, 32'd5, 32'd3);
        checks++;
        if (result !== 32'd8) begin
            errors++;
            $display("FAIL reset_release_add: got %h want 00000008", result);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [35:0] got;
        v.push_back('{4'd1,  32'd32,        32'd32,        {32'h00000000, 4'b1001}});
        v.push_back('{4'd1,  32'd32,        32'd64,        {32'hFFFFFFE0, 4'b0010}});
        v.push_back('{4'd0,  32'hFFFFFFFF,  32'd10,        {32'h00000009, 4'b1000}});
        v.push_back('{4'd0,  32'hFFFFFFFF,  32'd1,         {32'h00000000, 4'b1001}});
        v.push_back('{4'd0,  32'h7FFFFFFF,  32'd1,         {32'h80000000, 4'b0110}});
        v.push_back('{4'd1,  32'h80000000,  32'd1,         {32'h7FFFFFFF, 4'b1100}});
        v.push_back('{4'd8,  32'h80000000,  32'h21,        {32'hC0000000, 4'b0010}});
        v.push_back('{4'd9,  32'hFFFFFFFF,  32'd1,         {32'h00000001, 4'b0000}});
        v.push_back('{4'd10, 32'hFFFFFFFF,  32'd1,         {32'h00000000, 4'b0001}});
        v.push_back('{4'd15, 32'h12345678,  32'h9ABCDEF0,  {32'h00000000, 4'b0001}});
        v.push_back('{4'd6,  32'h12345678,  32'h20,        {32'h12345678, 4'b0000}});
        v.push_back('{4'd7,  32'h80000000,  32'h1F,        {32'h00000001, 4'b0000}});
        v.push_back('{4'd5,  32'h00000000,  32'h0,         {32'hFFFFFFFF, 4'b0010}});
        v.push_back('{4'd12, 32'hDEADBEEF,  32'h0000ABCD,  {32'h0000ABCD, 4'b0000}});
`ifdef ALU_MUL_EN
        v.push_back('{4'd11, 32'd6,         32'd7,         {32'd42,       4'b0000}});
`else
        v.push_back('{4'd11, 32'd6,         32'd7,         {32'd0,        4'b0001}});
`endif
        foreach (v[i]) begin
            step(v[i].op, v[i].a, v[i].b);
            got = {result, C_Flag, O_Flag, N_Flag, Z_Flag};
            checks++;
            if (got !== v[i].exp) begin
                errors++;
                $display("FAIL directed_%0d op=%0d: got %h/CONZ=%b want %h/CONZ=%b",
                         i, v[i].op, got[35:4], got[3:0], v[i].exp[35:4], v[i].exp[3:0]);
            end
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [35:0] exp, got;
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = rand_operand();
            b   = rand_operand();
            exp = ref_model(op, a, b);
            step(op, a, b);
            got = {result, C_Flag, O_Flag, N_Flag, Z_Flag};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h/CONZ=%b want %h/CONZ=%b",
                         i, op, a, b, got[35:4], got[3:0], exp[35:4], exp[3:0]);
            end
        end
    endtask

    // Continuous stream with reset pulses dropped in mid-stream.
    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [35:0] exp, got;
        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 12));
            a   = $urandom;
            b   = $urandom | 32'h1;
            rst = ((i % 15) == 7);
            exp = rst ? 36'd0 : ref_model(op, a, b);
            step(op, a, b);
            got = {result, C_Flag, O_Flag, N_Flag, Z_Flag};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_%0d rst=%0d op=%0d: got %h/CONZ=%b want %h/CONZ=%b",
                         i, rst, op, got[35:4], got[3:0], exp[35:4], exp[3:0]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
